// File: rtl/constant_update_controller_if.sv
// Config handshake bundle for constant_update_controller.
// Carries config_lock only when CONSTANT_UPDATE_CONTROLLER_LOCK_EN is defined.
interface constant_update_controller_if #(
    parameter int WORD_WIDTH = 8
);
    logic                  config_valid;
    logic                  config_ready;
    logic [WORD_WIDTH-1:0] config_value;
`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
    logic                  config_lock;

    modport master (output config_valid, output config_value, output config_lock, input config_ready);
    modport slave  (input config_valid, input config_value, input config_lock, output config_ready);
`else
    modport master (output config_valid, output config_value, input config_ready);
    modport slave  (input config_valid, input config_value, output config_ready);
`endif
endinterface

// File: rtl/constant_update_controller.sv
// Run-time-updatable constant: stage over ready/valid, apply on apply_enable, then settle.
// Optional lock-after-apply behaviour via CONSTANT_UPDATE_CONTROLLER_LOCK_EN.
//
// state   | meaning
// IDLE    | ready for a new config value
// PENDING | value staged in shadow, waiting for apply_enable
// SETTLE  | new constant applied, holding off further updates
// LOCKED  | (lock build only) constant frozen until clear
module constant_update_controller #(
    parameter int                    WORD_WIDTH    = 8,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE   = '0,
    parameter int                    SETTLE_CYCLES = 4
) (
    input  logic                          clock,
    input  logic                          clear,
    constant_update_controller_if.slave   cfg,
    input  logic                          apply_enable,
    output logic [WORD_WIDTH-1:0]         constant_out,
    output logic                          constant_changed,
    output logic                          busy
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SETTLE
`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
        , LOCKED
`endif
    } state_t;

    state_t                state, state_next, release_state;
    logic [WORD_WIDTH-1:0] shadow, shadow_next, constant_next;
    logic [CNT_W-1:0]      count, count_next;
    logic                  changed_next;
`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
    logic                  lock, lock_next;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state            <= IDLE;
            shadow           <= RESET_VALUE;
            constant_out     <= RESET_VALUE;
            count            <= '0;
            constant_changed <= 1'b0;
`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
            lock             <= 1'b0;
`endif
        end else begin
            state            <= state_next;
            shadow           <= shadow_next;
            constant_out     <= constant_next;
            count            <= count_next;
            constant_changed <= changed_next;
`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
            lock             <= lock_next;
`endif
        end
    end

    // Where an update sequence ends: IDLE normally, LOCKED if the staged lock bit was set.
    always_comb begin
        release_state = IDLE;
`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
        if (lock) release_state = LOCKED;
`endif
    end

    always_comb begin
        state_next    = state;
        shadow_next   = shadow;
        constant_next = constant_out;
        count_next    = count;
        changed_next  = 1'b0;
`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
        lock_next     = lock;
`endif
        case (state)
            IDLE: begin
                if (cfg.config_valid) begin
                    shadow_next = cfg.config_value;
`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
                    lock_next   = cfg.config_lock;
`endif
                    state_next  = PENDING;
                end
            end
            PENDING: begin
                if (apply_enable) begin
                    if (shadow != constant_out) begin
                        constant_next = shadow;
                        changed_next  = 1'b1;
                        count_next    = CNT_W'(SETTLE_CYCLES - 1);
                        state_next    = SETTLE;
                    end else begin
                        state_next = release_state;
                    end
                end
            end
            SETTLE: begin
                if (count == '0) state_next = release_state;
                else             count_next = count - 1'b1;
            end
`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
            LOCKED: state_next = LOCKED;
`endif
            default: state_next = IDLE;
        endcase
    end

    assign cfg.config_ready = (state == IDLE);
    assign busy             = (state != IDLE);
endmodule

// File: tb/tb_constant_update_controller.sv
// Scoreboard bench for constant_update_controller (WORD_WIDTH=8, RESET_VALUE=5A, SETTLE_CYCLES=3).
module tb_constant_update_controller;
    localparam int         WW  = 8;
    localparam logic [7:0] RV  = 8'h5A;
    localparam int         SC  = 3;

    logic          clock = 1'b0;
    logic          clear;
    logic          apply_enable;
    logic [WW-1:0] constant_out;
    logic          constant_changed;
    logic          busy;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int pulse_cnt  = 0;
    logic [WW-1:0] exp_q[$];

    constant_update_controller_if #(.WORD_WIDTH(WW)) cfg_if ();

    constant_update_controller #(
        .WORD_WIDTH(WW), .RESET_VALUE(RV), .SETTLE_CYCLES(SC)
    ) dut (
        .clock(clock),
        .clear(clear),
        .cfg(cfg_if.slave),
        .apply_enable(apply_enable),
        .constant_out(constant_out),
        .constant_changed(constant_changed),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Every constant_changed pulse must match the next value the stimulus queued.
    always @(negedge clock) begin
        if (constant_changed) begin
            pulse_cnt++;
            if (exp_q.size() == 0) check("unexpected_change", {24'h0, constant_out}, 32'hFFFF_FFFF);
            else                   check("sb_value", {24'h0, constant_out}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic do_reset();
        clear = 1'b1;
        cfg_if.config_valid = 1'b0;
        apply_enable = 1'b0;
        step();
        step();
        clear = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cfg_if.config_ready && n < 12) begin
            step();
            n++;
        end
        check(tag, {31'h0, cfg_if.config_ready}, 32'h1);
    endtask

    initial begin
        logic [WW-1:0] model_const;
        logic [WW-1:0] v;
        int            p0;

        clear = 1'b1;
        apply_enable = 1'b0;
        cfg_if.config_valid = 1'b0;
        cfg_if.config_value = '0;
`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
        cfg_if.config_lock = 1'b0;
`endif
        do_reset();
        check("rst_const", {24'h0, constant_out}, {24'h0, RV});
        check("rst_ready", {31'h0, cfg_if.config_ready}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_changed", {31'h0, constant_changed}, 32'h0);

        // Basic update with apply_enable already high.
        cfg_if.config_valid = 1'b1;
        cfg_if.config_value = 8'h3C;
        apply_enable = 1'b1;
        exp_q.push_back(8'h3C);
        step(); // E0
        cfg_if.config_valid = 1'b0;
        check("basic_e0_ready", {31'h0, cfg_if.config_ready}, 32'h0);
        check("basic_e0_const", {24'h0, constant_out}, {24'h0, RV});
        step(); // E1
        check("basic_e1_const", {24'h0, constant_out}, 32'h3C);
        check("basic_e1_changed", {31'h0, constant_changed}, 32'h1);
        step(); // E2
        check("basic_e2_changed", {31'h0, constant_changed}, 32'h0);
        check("basic_e2_ready", {31'h0, cfg_if.config_ready}, 32'h0);
        step(); // E3
        check("basic_e3_ready", {31'h0, cfg_if.config_ready}, 32'h0);
        step(); // E4
        check("basic_e4_ready", {31'h0, cfg_if.config_ready}, 32'h1);
        check("basic_e4_busy", {31'h0, busy}, 32'h0);

        // Stalled apply with a competing offer that must not be consumed.
        do_reset();
        cfg_if.config_valid = 1'b1;
        cfg_if.config_value = 8'h11;
        step();
        cfg_if.config_value = 8'h22;
        for (int i = 0; i < 10; i++) begin
            check("stall_const", {24'h0, constant_out}, {24'h0, RV});
            check("stall_busy", {31'h0, busy}, 32'h1);
            check("stall_ready", {31'h0, cfg_if.config_ready}, 32'h0);
            step();
        end
        apply_enable = 1'b1;
        exp_q.push_back(8'h11);
        step();
        cfg_if.config_valid = 1'b0;
        check("stall_apply_const", {24'h0, constant_out}, 32'h11);
        wait_ready("stall_ready_back");
        check("stall_final_const", {24'h0, constant_out}, 32'h11);

        // Equal value: no pulse, back to IDLE one edge after apply.
        do_reset();
        p0 = pulse_cnt;
        cfg_if.config_valid = 1'b1;
        cfg_if.config_value = RV;
        apply_enable = 1'b1;
        step();
        cfg_if.config_valid = 1'b0;
        step();
        check("equal_ready", {31'h0, cfg_if.config_ready}, 32'h1);
        check("equal_busy", {31'h0, busy}, 32'h0);
        check("equal_changed", {31'h0, constant_changed}, 32'h0);
        step();
        check("equal_no_pulse", pulse_cnt, p0);

        // clear while PENDING.
        do_reset();
        p0 = pulse_cnt;
        cfg_if.config_valid = 1'b1;
        cfg_if.config_value = 8'h77;
        step();
        cfg_if.config_valid = 1'b0;
        step();
        check("clrpend_busy", {31'h0, busy}, 32'h1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clrpend_const", {24'h0, constant_out}, {24'h0, RV});
        check("clrpend_ready", {31'h0, cfg_if.config_ready}, 32'h1);
        apply_enable = 1'b1;
        step();
        check("clrpend_no_apply", {24'h0, constant_out}, {24'h0, RV});
        check("clrpend_no_pulse", pulse_cnt, p0);

        // clear while SETTLE.
        do_reset();
        cfg_if.config_valid = 1'b1;
        cfg_if.config_value = 8'h77;
        apply_enable = 1'b1;
        exp_q.push_back(8'h77);
        step();
        cfg_if.config_valid = 1'b0;
        step();
        check("clrset_applied", {24'h0, constant_out}, 32'h77);
        step();
        check("clrset_busy", {31'h0, busy}, 32'h1);
        p0 = pulse_cnt;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clrset_const", {24'h0, constant_out}, {24'h0, RV});
        check("clrset_ready", {31'h0, cfg_if.config_ready}, 32'h1);
        step();
        check("clrset_no_pulse", pulse_cnt, p0);

        // Random updates with random apply delays, some repeating the current value.
        do_reset();
        model_const = RV;
        for (int i = 0; i < 12; i++) begin
            v = (i % 4 == 0) ? model_const : WW'($urandom);
            cfg_if.config_valid = 1'b1;
            cfg_if.config_value = v;
            apply_enable = 1'b0;
            step();
            cfg_if.config_valid = 1'b0;
            repeat ($urandom_range(0, 3)) step();
            apply_enable = 1'b1;
            if (v != model_const) exp_q.push_back(v);
            step();
            model_const = v;
            check("rand_const", {24'h0, constant_out}, {24'h0, model_const});
            wait_ready("rand_ready");
        end

`ifdef CONSTANT_UPDATE_CONTROLLER_LOCK_EN
        do_reset();
        cfg_if.config_valid = 1'b1;
        cfg_if.config_value = 8'h99;
        cfg_if.config_lock = 1'b1;
        apply_enable = 1'b1;
        exp_q.push_back(8'h99);
        step();
        cfg_if.config_valid = 1'b0;
        cfg_if.config_lock = 1'b0;
        step();
        check("lock_const", {24'h0, constant_out}, 32'h99);
        repeat (SC) step();
        cfg_if.config_valid = 1'b1;
        cfg_if.config_value = 8'h01;
        for (int i = 0; i < 20; i++) begin
            check("lock_ready", {31'h0, cfg_if.config_ready}, 32'h0);
            check("lock_busy", {31'h0, busy}, 32'h1);
            check("lock_frozen", {24'h0, constant_out}, 32'h99);
            step();
        end
        cfg_if.config_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("lock_clr_const", {24'h0, constant_out}, {24'h0, RV});
        check("lock_clr_ready", {31'h0, cfg_if.config_ready}, 32'h1);
`endif

        step();
        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/constant_update_controller.md
Name: constant_update_controller

Overview:
- Run-time-updatable constant source. Holds a WORD_WIDTH value on `constant_out` that downstream logic treats as static.
- Accepts new values over a ready/valid config port and stages each one in a shadow register.
- Applies the staged value only when the consumer asserts `apply_enable`, then enforces a settle window before it accepts another update.
- Sits between a config/CSR master and a datapath block that needs a quasi-static constant.

Parameters:
- WORD_WIDTH, 8, width of the constant and config words (>=1).
- RESET_VALUE, 0, value driven on `constant_out` after reset.
- SETTLE_CYCLES, 4, cycles `constant_out` is held stable after an applied change before a new config is accepted (>=1).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- clear  input  1  synchronous, active-high reset; overrides every other input.
- config_valid  input  1  new value offered.
- config_ready  output  1  controller can accept a value.
- config_value  input  WORD_WIDTH  offered value.
- apply_enable  input  1  consumer permits the constant to change this cycle.
- constant_out  output  WORD_WIDTH  current constant (registered).
- constant_changed  output  1  one-cycle pulse, high in the first cycle `constant_out` shows a new differing value.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high (`clear`), sampled on the rising edge of `clock`.
  - While `clear`=1, at each edge: constant_out=RESET_VALUE, shadow=RESET_VALUE, state=IDLE, settle counter=0, constant_changed=0.
  - Resulting outputs: config_ready=1, busy=0.
- States: IDLE, PENDING, SETTLE. Encoding is free; config_ready and busy decode from state.
- IDLE:
  - config_ready=1.
  - On config_valid&config_ready at an edge: shadow<=config_value, next state PENDING.
- PENDING:
  - config_ready=0; config_valid is ignored and the offered value is not consumed.
  - If apply_enable=1 and shadow!=constant_out: at the edge, constant_out<=shadow, constant_changed<=1, counter<=SETTLE_CYCLES-1, next state SETTLE.
  - If apply_enable=1 and shadow==constant_out: no change, constant_changed stays 0, next state IDLE.
  - If apply_enable=0: remain in PENDING indefinitely; constant_out unchanged.
- SETTLE:
  - config_ready=0.
  - If counter==0: next state IDLE; otherwise counter decrements.
  - SETTLE lasts exactly SETTLE_CYCLES cycles.
- constant_changed is registered and high for exactly one cycle per applied differing value.
- Latency, handshake edge E0 to constant_out update: 1 edge minimum (E1 when apply_enable=1 during the cycle after E0).
- config_ready re-asserts SETTLE_CYCLES edges after the apply edge.
- apply_enable is sampled only in PENDING.
- clear during PENDING or SETTLE: the staged value is discarded, constant_out returns to RESET_VALUE, and no constant_changed pulse is produced.
- Counter width: clog2(SETTLE_CYCLES)+1 bits; no wrap is possible.

Optional Feature:
- Macro: CONSTANT_UPDATE_CONTROLLER_LOCK_EN.
- Defined:
  - Adds input port `config_lock` (1 bit), sampled with the config handshake and stored beside the shadow.
  - If the stored lock=1, the controller enters LOCKED after apply (or after the equal-value skip) instead of IDLE. When SETTLE is used, LOCKED is entered at its end.
  - LOCKED: config_ready=0, busy=1, constant_out frozen. Only `clear` exits, to IDLE.
- Not defined: the port, the lock storage and the LOCKED state are absent. Behaviour is exactly as above.

Test Plan:
- Parameters for all scenarios: WORD_WIDTH=8, RESET_VALUE=8'h5A, SETTLE_CYCLES=3.
- Reset: clear=1 for 2 cycles -> constant_out=8'h5A, config_ready=1, busy=0, constant_changed=0.
- Basic update: handshake 8'h3C at E0 with apply_enable=1 -> constant_out=8'h3C after E1; constant_changed=1 only between E1 and E2; config_ready=0 from E0 until E4, then 1.
- Stalled apply: handshake 8'h11, apply_enable=0 for 10 cycles -> constant_out stays 8'h5A, busy=1. Concurrent config_valid with 8'h22 is not accepted. Raise apply_enable -> constant_out=8'h11 next edge, never 8'h22.
- Equal value: handshake 8'h5A from reset, apply_enable=1 -> no constant_changed pulse; IDLE and config_ready=1 one edge after apply.
- Reset mid-operation: handshake 8'h77, apply_enable=0, assert clear in PENDING -> constant_out=8'h5A, no constant_changed pulse. Same check for clear asserted in SETTLE after 8'h77 is applied -> constant_out returns to 8'h5A.
- With CONSTANT_UPDATE_CONTROLLER_LOCK_EN: handshake 8'h99 with config_lock=1 -> constant_out=8'h99. After settle, config_ready stays 0 for 20 cycles and busy=1. Then clear -> constant_out=8'h5A, config_ready=1.
